rgb_led_sched: RTL and testbench

Priority scheduler and PWM driver for the board's shared active-low RGB status LED. Three requesters (0 = alarm, 1 = warning, 2 = status) each present a colour and a blink flag. The block grants the LED to one owner at a time and inserts a visible dark gap on every ownership change. It produces the dimmed, optionally blinking active-low rgb drive and sits between the monitor logic and the LED pins.

---
 rtl/rgb_led_sched.sv | 154 +++++++++++++++
 tb/tb_rgb_led_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sched.sv
// Priority scheduler and PWM driver for a shared active-low RGB status LED.
// Define RGB_LED_SCHED_PWM_EN to enable lvl-based PWM dimming; without it channels run at full duty.
module rgb_led_sched #(
    parameter int unsigned PRESCALE    = 12000,
    parameter int unsigned GAP_TICKS   = 100,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [8:0] color,
    input  logic [2:0] blink,
    input  logic [7:0] lvl,
    output logic [2:0] grant,
    output logic [2:0] rgb
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t        state;
    logic [PW-1:0] presc_cnt;
    logic [GW-1:0] gap_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic          tick;
    logic          gap_done;
    logic          leave;
    logic [2:0]    higher;
    logic [2:0]    owner_color;
    logic          owner_blink;
    logic [2:0]    lit;
    logic [2:0]    drive;

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[0])      return 3'b001;
        else if (r[1]) return 3'b010;
        else if (r[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    assign tick = (presc_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc_cnt <= '0;
        else if (tick) presc_cnt <= '0;
        else           presc_cnt <= presc_cnt + 1'b1;
    end

    // Sources with a lower index than the current owner may preempt it.
    assign higher   = {1'b0, grant[2], grant[2] | grant[1]};
    assign leave    = ~(|(req & grant)) | (|(req & higher));
    assign gap_done = (GAP_TICKS == 0) ? 1'b1 : (tick && gap_cnt == GW'(GAP_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            gap_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= ACTIVE;
                        grant     <= pick(req);
                        blink_cnt <= '0;
                        phase     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (leave) begin
                        state   <= GAP;
                        grant   <= '0;
                        gap_cnt <= '0;
                    end else if (tick) begin
                        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                            blink_cnt <= '0;
                            phase     <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (|req) begin
                            state     <= ACTIVE;
                            grant     <= pick(req);
                            blink_cnt <= '0;
                            phase     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tick) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Colour and blink follow the owner's inputs live rather than a copy taken at grant.
    always_comb begin
        owner_color = '0;
        owner_blink = 1'b0;
        if (grant[0]) begin
            owner_color = color[2:0];
            owner_blink = blink[0];
        end else if (grant[1]) begin
            owner_color = color[5:3];
            owner_blink = blink[1];
        end else if (grant[2]) begin
            owner_color = color[8:6];
            owner_blink = blink[2];
        end
    end

    assign lit = (state == ACTIVE) ? (owner_color & {3{phase | ~owner_blink}}) : 3'b000;

`ifdef RGB_LED_SCHED_PWM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] lvl_q;

    // lvl_q only reloads at the period boundary so duty never changes mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            lvl_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) lvl_q <= lvl;
        end
    end

    assign drive = lit & {3{pwm_cnt < lvl_q}};
`else
    logic unused_lvl;
    assign unused_lvl = ^lvl;
    assign drive      = lit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= 3'b111;
        else        rgb <= ~drive;
    end
endmodule

// File: tb/tb_rgb_led_sched.sv
// Directed bench for rgb_led_sched: vector table for arbitration plus sequences for gaps, blink, PWM and reset.
module tb_rgb_led_sched;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req   = '0;
    logic [8:0] color = '0;
    logic [2:0] blink = '0;
    logic [7:0] lvl   = 8'd255;
    logic [2:0] grant, rgb, grant0, rgb0;

    int n_vec = 0;
    int n_err = 0;

    // Reference counters: edges since reset release, PWM count, latched level and gate used by rgb.
    int         m_cyc;
    logic [7:0] m_pwm, m_lvlq;
    logic       m_gate;

    typedef struct packed {
        logic [2:0] req;
        logic [8:0] color;
        logic [2:0] blink;
        logic [2:0] grant;
        logic [2:0] lit;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    rgb_led_sched #(.PRESCALE(4), .GAP_TICKS(2), .BLINK_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .color(color), .blink(blink), .lvl(lvl),
        .grant(grant), .rgb(rgb)
    );

    rgb_led_sched #(.PRESCALE(4), .GAP_TICKS(0), .BLINK_TICKS(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .color(color), .blink(blink), .lvl(lvl),
        .grant(grant0), .rgb(rgb0)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            m_pwm  <= '0;
            m_lvlq <= '0;
            m_gate <= 1'b0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_gate <= (m_pwm < m_lvlq);
            if (m_pwm == 8'd255) m_lvlq <= lvl;
            m_pwm  <= m_pwm + 8'd1;
        end
    end

    function automatic logic [2:0] exp_rgb(input logic [2:0] lit);
`ifdef RGB_LED_SCHED_PWM_EN
        return m_gate ? ~lit : 3'b111;
`else
        return ~lit;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Gap length depends on prescaler phase at GAP entry: 1 + clks to first tick + one tick period + 1.
    task automatic measure_gap(input string name, input logic [2:0] new_req,
                               input logic [2:0] owner, input logic [2:0] lit);
        int e;
        int n;
        int exp_n;
        req = new_req;
        step;
        e = m_cyc;
        exp_n = ((3 - (e % 4)) % 4) + 5;
        check({name, "_enter"}, grant, 3'b000);
        check({name, "_enter_g0"}, grant0, 3'b000);
        step;
        check({name, "_gap0_one_clk"}, grant0, owner);
        n = 1;
        while (grant == 3'b000 && n < 20) begin
            n++;
            step;
        end
        check({name, "_gap_len"}, n, exp_n);
        check({name, "_owner"}, grant, owner);
        step;
        check({name, "_rgb"}, rgb, exp_rgb(lit));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] g_or, g_and, r_and;
        logic [1:0] gb_and;
        logic       ph;
        int         tcnt;
        int         lows;
        int         exp_lo, exp_hi;

        tbl[0] = '{req: 3'b100, color: 9'b010_000_000, blink: 3'b000, grant: 3'b100, lit: 3'b010};
        tbl[1] = '{req: 3'b001, color: 9'b000_000_001, blink: 3'b000, grant: 3'b001, lit: 3'b001};
        tbl[2] = '{req: 3'b011, color: 9'b000_100_011, blink: 3'b000, grant: 3'b001, lit: 3'b011};
        tbl[3] = '{req: 3'b110, color: 9'b001_110_000, blink: 3'b000, grant: 3'b010, lit: 3'b110};
        tbl[4] = '{req: 3'b111, color: 9'b111_111_111, blink: 3'b111, grant: 3'b001, lit: 3'b111};
        tbl[5] = '{req: 3'b010, color: 9'b111_000_111, blink: 3'b000, grant: 3'b010, lit: 3'b000};
        tbl[6] = '{req: 3'b100, color: 9'b101_010_010, blink: 3'b100, grant: 3'b100, lit: 3'b101};

`ifdef RGB_LED_SCHED_PWM_EN
        exp_lo = 64;
        exp_hi = 192;
`else
        exp_lo = 256;
        exp_hi = 256;
`endif

        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 3'b000);
        check("rst_rgb", rgb, 3'b111);
        repeat (3) step;
        rst_n = 1'b1;

        g_or  = '0;
        r_and = '1;
        repeat (1000) begin
            step;
            g_or  |= grant;
            r_and &= rgb;
        end
        check("hold_grant", g_or, 3'b000);
        check("hold_rgb", r_and, 3'b111);

        for (int i = 0; i < 7; i++) begin
            req = '0;
            repeat (20) step;
            color = tbl[i].color;
            blink = tbl[i].blink;
            req   = tbl[i].req;
            step;
            check($sformatf("vec%0d_rgb_lag", i), rgb, 3'b111);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
            step;
            check($sformatf("vec%0d_rgb", i), rgb, exp_rgb(tbl[i].lit));
        end

        req = '0;
        repeat (20) step;
        color = 9'b010_000_001;
        blink = '0;
        req   = 3'b100;
        step;
        check("pre_grant2", grant, 3'b100);
        repeat (4) step;
        check("pre_rgb2", rgb, exp_rgb(3'b010));
        measure_gap("preempt", 3'b101, 3'b001, 3'b001);

        req = 3'b001;
        repeat (3) step;
        req   = 3'b101;
        g_or  = '0;
        g_and = '1;
        repeat (12) begin
            step;
            g_or  |= grant;
            g_and &= grant;
        end
        check("low_no_preempt", {g_or, g_and}, 6'b001_001);

        req = '0;
        repeat (20) step;
        color = 9'b000_000_111;
        blink = 3'b001;
        req   = 3'b001;
        step;
        check("blink_grant", grant, 3'b001);
        ph   = 1'b1;
        tcnt = 0;
        for (int i = 0; i < 60; i++) begin
            step;
            check($sformatf("blink_c%0d", i), rgb, exp_rgb(ph ? 3'b111 : 3'b000));
            if (((m_cyc - 1) % 4) == 3) tcnt++;
            ph = ((tcnt / 3) % 2) == 0;
        end

        color = 9'b000_000_001;
        blink = '0;
        lvl   = 8'd64;
        step;
        for (int i = 0; i < 600 && (m_cyc % 256) != 0; i++) step;
        lows   = 0;
        gb_and = '1;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) lvl = 8'd192;
            step;
            if (!rgb[0]) lows++;
            gb_and &= rgb[2:1];
        end
        check("pwm_lvl64", lows, exp_lo);
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            step;
            if (!rgb[0]) lows++;
            gb_and &= rgb[2:1];
        end
        check("pwm_lvl192", lows, exp_hi);
        check("pwm_gb_dark", gb_and, 2'b11);

        req = '0;
        lvl = 8'd255;
        repeat (20) step;
        color = 9'b000_100_001;
        req   = 3'b010;
        step;
        check("simul_grant1", grant, 3'b010);
        repeat (3) step;
        measure_gap("simul", 3'b001, 3'b001, 3'b001);

        #2 rst_n = 1'b0;
        #1;
        check("arst_grant", grant, 3'b000);
        check("arst_rgb", rgb, 3'b111);
        check("arst_rgb0", rgb0, 3'b111);
        repeat (2) step;
        check("arst_hold_grant", grant, 3'b000);
        rst_n = 1'b1;
        step;
        check("post_rst_grant", grant, 3'b001);
        check("post_rst_rgb_lag", rgb, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
